fft_result_usb_tx: RTL

Transmit side of the FX2 slave-FIFO link. Accepts one complete FFT result frame (2^NPOINT complex points, 16-bit real/imag) from the FFT core over a valid/busy handshake and streams it to the FX2 IN endpoint (EP6) as 16-bit words. It shares the FX2 bus with the receive path, which loads weights and input data, through a request/grant pair owned by the top-level arbiter.

---
 rtl/fft_result_usb_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_result_usb_tx.sv
// fft_result_usb_tx
// Transmit side of the FX2 slave-FIFO link. Takes one complete FFT result
// frame (2^NPOINT complex points, 16-bit real/imag) over a valid/busy
// handshake, requests the shared FX2 bus from the top-level arbiter, and
// streams the frame to EP6 as 2^(NPOINT+1) 16-bit words ordered
// real[0], imag[0], real[1], imag[1], ...
//
// Ports:
//   clk, rst_n          system clock (FX2 IFCLK domain), async active-low reset
//   fft_dout_valid      result frame available (sampled only in IDLE)
//   fft_dout_busy       frame held; upstream must not present another
//   fft_dout_real/imag  point i at bits [16i+15:16i]
//   tx_req / tx_gnt     FX2 bus request / grant
//   fx2_flagc           EP6 almost-full flag, active low (0 = stop writing)
//   fx2_a               FIFO address, 2'b10 while owning the bus
//   fx2_slwr_n          write strobe, active low
//   fx2_pktend_n        packet-end strobe, active low
//   fx2_db_out          write data
//   fx2_db_oe           data bus drive enable for the top-level tristate
//
// Build option: define USB_TX_PKTEND_EN to pulse fx2_pktend_n for one cycle
// right after the last word (short-packet commit). Without it fx2_pktend_n
// stays high and the FX2 auto-commits on packet size.

module fft_result_usb_tx #(
  parameter int NPOINT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fft_dout_valid,
  output logic                        fft_dout_busy,
  input  logic [16*(2**NPOINT)-1:0]   fft_dout_real,
  input  logic [16*(2**NPOINT)-1:0]   fft_dout_imag,
  output logic                        tx_req,
  input  logic                        tx_gnt,
  input  logic                        fx2_flagc,
  output logic [1:0]                  fx2_a,
  output logic                        fx2_slwr_n,
  output logic                        fx2_pktend_n,
  output logic [15:0]                 fx2_db_out,
  output logic                        fx2_db_oe
);

  localparam int VW = 16 * (2**NPOINT);
  localparam int CW = NPOINT + 1;
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] EP6_ADDR = 2'b10;

  logic [2:0]    state_q,  state_d;
  logic [VW-1:0] real_q,   real_d;
  logic [VW-1:0] imag_q,   imag_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          busy_q,   busy_d;
  logic          req_q,    req_d;
  logic [1:0]    a_q,      a_d;
  logic          slwr_n_q, slwr_n_d;
  logic          pktend_n_q, pktend_n_d;
  logic [15:0]   dout_q,   dout_d;
  logic          oe_q,     oe_d;

  // Next-state and next-output logic; every output is computed here one
  // cycle ahead and registered below.
  always_comb begin
    state_d    = state_q;
    real_d     = real_q;
    imag_d     = imag_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    req_d      = req_q;
    a_d        = a_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    dout_d     = dout_q;
    oe_d       = oe_q;

    case (state_q)
      S_IDLE: begin
        if (fft_dout_valid) begin
          real_d  = fft_dout_real;
          imag_d  = fft_dout_imag;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ARB: begin
        if (tx_gnt) begin
          a_d     = EP6_ADDR;
          oe_d    = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_ARB;
        end
      end

      S_SETUP: begin
        cnt_d   = {CW{1'b0}};
        state_d = S_WRITE;
      end

      S_WRITE: begin
        // Flag sampled at this edge decides whether a word goes out from it;
        // on a stall strobe stays high and data/counter hold.
        if (fx2_flagc) begin
          slwr_n_d = 1'b0;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q[0]) begin
            // Odd word: imag of the current point, then advance both
            // shift registers to the next point.
            dout_d = imag_q[15:0];
            real_d = {16'h0000, real_q[VW-1:16]};
            imag_d = {16'h0000, imag_q[VW-1:16]};
          end else begin
            dout_d = real_q[15:0];
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_FLUSH: begin
        // The last strobe is on the bus during this cycle; the bus drive is
        // released at the edge leaving FLUSH.
`ifdef USB_TX_PKTEND_EN
        pktend_n_d = 1'b0;
`else
        pktend_n_d = 1'b1;
`endif
        oe_d    = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        a_d     = 2'b00;
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        a_d     = 2'b00;
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      real_q     <= {VW{1'b0}};
      imag_q     <= {VW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      a_q        <= 2'b00;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      dout_q     <= 16'h0000;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      real_q     <= real_d;
      imag_q     <= imag_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      a_q        <= a_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
    end
  end

  assign fft_dout_busy = busy_q;
  assign tx_req        = req_q;
  assign fx2_a         = a_q;
  assign fx2_slwr_n    = slwr_n_q;
  assign fx2_pktend_n  = pktend_n_q;
  assign fx2_db_out    = dout_q;
  assign fx2_db_oe     = oe_q;

endmodule
